// File: rtl/edc_pkg.sv
// Shared constants for the SECDED scrubber: code widths, the data-bit position
// table of the Hamming(38,32) code, and the write-back FSM state encoding.
package edc_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CHK_W  = 7;
   localparam int unsigned CODE_N = 38;
   localparam int unsigned SYN_W  = 6;
   localparam int unsigned ADDR_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_DATA = 2'd1,
      ST_WR_PAR  = 2'd2
   } scrub_state_t;

   // Code position of d[k]: every non-power-of-two position in 1..38, ascending.
   localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
      6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
      6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
      6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
      6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
   };

endpackage

// File: rtl/edc_encode.sv
// Combinational SECDED check-bit generator: p[5:0] Hamming bits over the data
// positions, p[6] overall parity over data and p[5:0].
module edc_encode
   import edc_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   output logic [CHK_W-1:0]  o_parity
);

   logic [SYN_W-1:0] w_p;

   always_comb begin
      w_p = '0;
      for (int i = 0; i < int'(SYN_W); i++) begin
         for (int k = 0; k < int'(DATA_W); k++) begin
            if (DATA_POS[k][i]) begin
               w_p[i] = w_p[i] ^ i_data[k];
            end
         end
      end
   end

   assign o_parity = {(^i_data) ^ (^w_p), w_p};

endmodule

// File: rtl/edc_scrub.sv
// Two-stage SECDED check/correct pipeline for cache reads, with a two-cycle
// write-back of corrected words and saturating SEC/DED counters.
module edc_scrub
   import edc_pkg::*;
#(
   parameter int COUNT_W  = 16,
   parameter int SCRUB_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADDR_W-1:0]  in_addr,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [CHK_W-1:0]   in_parity,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_sec,
   output logic               out_ded,
   output logic               error_dwe,
   output logic               error_pwe,
   output logic [ADDR_W-1:0]  error_addr,
   output logic [DATA_W-1:0]  error_din,
   output logic [CHK_W-1:0]   error_pin,
   input  logic               clear_counts,
   output logic [COUNT_W-1:0] sec_count,
   output logic [COUNT_W-1:0] ded_count,
   output logic [1:0]         o_dbg_state
);

   scrub_state_t r_state, w_state_nxt;

   logic [CHK_W-1:0]   w_in_chk, w_wb_chk;
   logic [SYN_W-1:0]   w_syn;
   logic               w_ov, w_run, w_start;

   logic               r_s1_valid, r_s1_ov;
   logic [DATA_W-1:0]  r_s1_data;
   logic [ADDR_W-1:0]  r_s1_addr;
   logic [SYN_W-1:0]   r_s1_syn;

   logic [DATA_W-1:0]  w_corr;
   logic               w_sec, w_ded;

   logic               r_out_valid, r_out_sec, r_out_ded;
   logic [DATA_W-1:0]  r_out_data;
   logic [ADDR_W-1:0]  r_out_addr;

   logic [ADDR_W-1:0]  r_wb_addr;
   logic [DATA_W-1:0]  r_wb_data;
   logic [COUNT_W-1:0] r_sec_count, r_ded_count;

   edc_encode u_enc_in (.i_data(in_data),   .o_parity(w_in_chk));
   edc_encode u_enc_wb (.i_data(r_wb_data), .o_parity(w_wb_chk));

   // XOR of all generated check bits collapses to ^in_data, so this is the
   // parity of all 39 received bits.
   assign w_syn = w_in_chk[SYN_W-1:0] ^ in_parity[SYN_W-1:0];
   assign w_ov  = (^w_in_chk) ^ (^in_parity);
   assign w_run = (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_ov    <= 1'b0;
         r_s1_data  <= '0;
         r_s1_addr  <= '0;
         r_s1_syn   <= '0;
      end else if (w_run) begin
         r_s1_valid <= in_valid;
         r_s1_ov    <= w_ov;
         r_s1_data  <= in_data;
         r_s1_addr  <= in_addr;
         r_s1_syn   <= w_syn;
      end
   end

   // Power-of-two and zero syndromes never match a data position, so only a
   // data-bit error flips anything.
   always_comb begin
      w_corr = r_s1_data;
      if (r_s1_ov) begin
         for (int k = 0; k < int'(DATA_W); k++) begin
            if (DATA_POS[k] == r_s1_syn) begin
               w_corr[k] = ~r_s1_data[k];
            end
         end
      end
      w_sec = r_s1_valid && r_s1_ov && ({26'd0, r_s1_syn} <= CODE_N);
      w_ded = r_s1_valid && ((!r_s1_ov && (r_s1_syn != '0)) ||
                             (r_s1_ov && ({26'd0, r_s1_syn} > CODE_N)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_sec   <= 1'b0;
         r_out_ded   <= 1'b0;
         r_out_data  <= '0;
         r_out_addr  <= '0;
      end else if (w_run) begin
         r_out_valid <= r_s1_valid;
         r_out_sec   <= w_sec;
         r_out_ded   <= w_ded;
         r_out_data  <= w_corr;
         r_out_addr  <= r_s1_addr;
      end else begin
         r_out_valid <= 1'b0;
         r_out_sec   <= 1'b0;
         r_out_ded   <= 1'b0;
      end
   end

   // An SEC emerging in the first write-back cycle is counted but not scrubbed.
   assign w_start = (SCRUB_EN != 0) && w_run && r_out_valid && r_out_sec;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else if (w_start) begin
         r_wb_addr <= r_out_addr;
         r_wb_data <= r_out_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      error_dwe   = 1'b0;
      error_pwe   = 1'b0;
      error_addr  = '0;
      error_din   = '0;
      error_pin   = '0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (w_start) w_state_nxt = ST_WR_DATA;
         end
         ST_WR_DATA: begin
            error_dwe   = 1'b1;
            error_addr  = r_wb_addr;
            error_din   = r_wb_data;
            w_state_nxt = ST_WR_PAR;
         end
         ST_WR_PAR: begin
            error_pwe   = 1'b1;
            error_addr  = r_wb_addr;
            error_pin   = w_wb_chk;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear_counts) begin
         r_sec_count <= '0;
         r_ded_count <= '0;
      end else begin
         if (r_out_valid && r_out_sec && (r_sec_count != '1)) begin
            r_sec_count <= r_sec_count + COUNT_W'(1);
         end
         if (r_out_valid && r_out_ded && (r_ded_count != '1)) begin
            r_ded_count <= r_ded_count + COUNT_W'(1);
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_sec     = r_out_sec;
   assign out_ded     = r_out_ded;
   assign sec_count   = r_sec_count;
   assign ded_count   = r_ded_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_edc_scrub.sv
// Bench for edc_scrub: directed scenarios plus random corrupted words, scored
// against a position-based Hamming model and a cycle-level handshake model.
module tb_edc_scrub;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [8:0]    in_addr = '0;
   logic [31:0]   in_data = '0;
   logic [6:0]    in_parity = '0;
   logic          out_valid, out_sec, out_ded;
   logic [31:0]   out_data;
   logic          error_dwe, error_pwe;
   logic [8:0]    error_addr;
   logic [31:0]   error_din;
   logic [6:0]    error_pin;
   logic          clear_counts = 1'b0;
   logic [CW-1:0] sec_count, ded_count;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   edc_scrub #(.COUNT_W(CW), .SCRUB_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_parity(in_parity),
      .out_valid(out_valid), .out_data(out_data), .out_sec(out_sec), .out_ded(out_ded),
      .error_dwe(error_dwe), .error_pwe(error_pwe), .error_addr(error_addr),
      .error_din(error_din), .error_pin(error_pin), .clear_counts(clear_counts),
      .sec_count(sec_count), .ded_count(ded_count), .o_dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: codeword indexed by position ----------
   function automatic bit is_pow2(input int j);
      return (j & (j - 1)) == 0;
   endfunction

   // Bit j of the result is code position j (1..38); bit 0 holds p6.
   function automatic logic [38:0] place(input logic [31:0] d, input logic [6:0] p);
      logic [38:0] cw;
      int k, pi;
      cw = '0; k = 0; pi = 0;
      for (int j = 1; j <= 38; j++) begin
         if (is_pow2(j)) begin cw[j] = p[pi]; pi++; end
         else begin cw[j] = d[k]; k++; end
      end
      cw[0] = p[6];
      return cw;
   endfunction

   function automatic logic [31:0] extract(input logic [38:0] cw);
      logic [31:0] d;
      int k;
      d = '0; k = 0;
      for (int j = 1; j <= 38; j++) begin
         if (!is_pow2(j)) begin d[k] = cw[j]; k++; end
      end
      return d;
   endfunction

   function automatic logic [6:0] m_encode(input logic [31:0] d);
      logic [38:0] cw;
      logic [6:0]  p;
      cw = place(d, 7'd0);
      p  = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 1; j <= 38; j++)
            if ((((j >> i) & 1) != 0) && cw[j]) p[i] = ~p[i];
      p[6] = (^cw) ^ (^p[5:0]);
      return p;
   endfunction

   task automatic m_decode(input logic [31:0] d, input logic [6:0] p,
                           output logic [31:0] cd, output bit sec, output bit ded);
      logic [38:0] cw;
      int syn;
      bit ov;
      cw  = place(d, p);
      syn = 0;
      for (int j = 1; j <= 38; j++) if (cw[j]) syn = syn ^ j;
      ov  = ^cw;
      sec = ov && (syn <= 38);
      ded = (!ov && syn != 0) || (ov && syn > 38);
      cd  = d;
      if (sec && syn != 0 && !is_pow2(syn)) begin
         cw[syn] = ~cw[syn];
         cd = extract(cw);
      end
   endtask

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] data;
      bit          sec;
      bit          ded;
      int          idle;
   } exp_t;

   exp_t        exp_q[$];
   int          wb_phase = 0;
   logic [8:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   int          m_sec = 0;
   int          m_ded = 0;

   // ---------------- monitor / scoreboard (samples on falling edge) ---------
   initial begin
      exp_t        head, nw;
      bit          exp_ov, sec_now, ded_now, idle_now;
      logic [31:0] cd;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_ov = (exp_q.size() > 0) && (exp_q[0].idle == 2);
         check("out_valid", out_valid, exp_ov);
         check("in_ready", in_ready, wb_phase == 0);
         check("error_dwe", error_dwe, wb_phase == 1);
         check("error_pwe", error_pwe, wb_phase == 2);
         if (wb_phase == 1) begin
            check("wb_data_addr", error_addr, wb_addr);
            check("wb_din", error_din, wb_data);
         end
         if (wb_phase == 2) begin
            check("wb_par_addr", error_addr, wb_addr);
            check("wb_pin", error_pin, m_encode(wb_data));
         end
         check("sec_count", sec_count, m_sec);
         check("ded_count", ded_count, m_ded);
         sec_now = 0; ded_now = 0;
         if (exp_ov) begin
            head = exp_q.pop_front();
            check("out_data", out_data, head.data);
            check("out_sec", out_sec, head.sec);
            check("out_ded", out_ded, head.ded);
            sec_now = head.sec; ded_now = head.ded;
         end
         if (rst) begin
            wb_phase = 0; m_sec = 0; m_ded = 0;
            exp_q.delete();
         end else begin
            if (clear_counts) begin
               m_sec = 0; m_ded = 0;
            end else begin
               if (sec_now && m_sec < (1 << CW) - 1) m_sec++;
               if (ded_now && m_ded < (1 << CW) - 1) m_ded++;
            end
            idle_now = (wb_phase == 0);
            if (wb_phase == 1) wb_phase = 2;
            else if (wb_phase == 2) wb_phase = 0;
            else if (sec_now) begin
               wb_phase = 1; wb_addr = head.addr; wb_data = head.data;
            end
            if (idle_now) begin
               foreach (exp_q[i]) exp_q[i].idle = exp_q[i].idle + 1;
               if (in_valid) begin
                  m_decode(in_data, in_parity, cd, nw.sec, nw.ded);
                  nw.addr = in_addr; nw.data = cd; nw.idle = 1;
                  exp_q.push_back(nw);
               end
            end
         end
      end
   end

   // ---------------- driver tasks (drive #1 after rising edge) ---------------
   task automatic send_word(input logic [8:0] a, input logic [31:0] d, input logic [6:0] p);
      bit acc;
      int n;
      acc = 0; n = 0;
      in_valid = 1'b1; in_addr = a; in_data = d; in_parity = p;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 20);
      check("accept_within_bound", acc, 1'b1);
   endtask

   task automatic idle(input int n, output int lows);
      lows = 0;
      in_valid = 1'b0;
      repeat (n) begin
         if (!in_ready) lows++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [6:0]  p, pg;
      int          lows, b;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sec_count", sec_count, 0);
      check("rst_strobes", {error_dwe, error_pwe}, 2'b00);

      pg = m_encode(32'hDEADBEEF);
      send_word(9'h005, 32'hDEADBEEF, pg);
      idle(6, lows);
      send_word(9'h1A0, 32'hDEADBEEF ^ 32'h0000_0020, pg);
      idle(6, lows);
      check("sec_after_single", sec_count, 1);
      send_word(9'h033, 32'hDEADBEEF ^ 32'h8000_0001, pg);
      idle(6, lows);
      check("ded_after_double", ded_count, 1);

      // back-to-back clean / SEC / clean
      send_word(9'h010, 32'h1234_5678, m_encode(32'h1234_5678));
      send_word(9'h011, 32'hCAFE_F00D ^ 32'h0001_0000, m_encode(32'hCAFE_F00D));
      send_word(9'h012, 32'h0BAD_CAFE, m_encode(32'h0BAD_CAFE));
      idle(10, lows);
      check("b2b_ready_low_cycles", lows, 2);

      // counter saturation and clear priority
      clear_counts = 1'b1; @(posedge clk); #1 clear_counts = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = $urandom; p = m_encode(d);
         b = $urandom_range(0, 31);
         d[b] = ~d[b];
         send_word(9'(i), d, p);
         idle(6, lows);
      end
      check("sec_saturated", sec_count, 3);
      send_word(9'h0AA, 32'h5555_AAAA ^ 32'h0000_0100, m_encode(32'h5555_AAAA));
      in_valid = 1'b0;
      @(posedge clk); #1 clear_counts = 1'b1;
      @(posedge clk); #1 clear_counts = 1'b0;
      check("clear_over_increment", sec_count, 0);
      idle(6, lows);

      // reset during the parity write
      send_word(9'h0F0, 32'hA5A5_5A5A ^ 32'h0000_4000, m_encode(32'hA5A5_5A5A));
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("in_wr_par_pwe", error_pwe, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("abort_pwe", error_pwe, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_sec_count", sec_count, 0);
      check("abort_ded_count", ded_count, 0);
      idle(3, lows);

      // random corrupted words
      for (int i = 0; i < 300; i++) begin
         clear_counts = ($urandom_range(0, 19) == 0);
         d = $urandom; p = m_encode(d);
         repeat ($urandom_range(0, 3)) begin
            b = $urandom_range(0, 38);
            if (b < 32) d[b] = ~d[b];
            else p[b - 32] = ~p[b - 32];
         end
         send_word(9'($urandom_range(0, 511)), d, p);
         if ($urandom_range(0, 2) == 0) begin
            clear_counts = 1'b0;
            idle($urandom_range(1, 3), lows);
         end
      end
      clear_counts = 1'b0;
      idle(12, lows);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/edc_scrub.md
EDC_SCRUB -- requirements
Module: edc_scrub

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the error counters.
REQ-002 SHALL have parameter SCRUB_EN, default 1: 1 enables write-back of corrected words.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: a read word is presented.
REQ-006 SHALL have port in_ready, output, 1: the word is accepted when in_valid && in_ready.
REQ-007 SHALL have port in_addr, input, 9: cache data index of the word.
REQ-008 SHALL have port in_data, input, 32: stored data word.
REQ-009 SHALL have port in_parity, input, 7: stored SECDED check bits.
REQ-010 SHALL have port out_valid, output, 1: one-cycle pulse qualifying the out_* ports.
REQ-011 SHALL have port out_data, output, 32: the corrected word.
REQ-012 SHALL have port out_sec, output, 1: a single error was corrected.
REQ-013 SHALL have port out_ded, output, 1: an uncorrectable double error was detected.
REQ-014 SHALL have ports error_dwe/error_pwe, output, 1 each: data and parity write strobes to the cache.
REQ-015 SHALL have ports error_addr (9), error_din (32) and error_pin (7), outputs: cache write-back address and payloads.
REQ-016 SHALL have port clear_counts, input, 1: zeroes both counters.
REQ-017 SHALL have ports sec_count and ded_count, output, COUNT_W each: error tallies.

Function
REQ-018 SHALL use a Hamming(38,32) code with positions 1..38; p[5:0] sit at positions 1,2,4,8,16,32; d[0..31] fill the remaining positions in ascending order (d0 at position 3).
REQ-019 SHALL define p[i] as the XOR of the data bits whose position has bit i set, and p[6] as the XOR of d[31:0] and p[5:0].
REQ-020 SHALL compute syndrome s[5:0] = recomputed p[5:0] XOR in_parity[5:0], and ov = XOR of all 39 received bits.
REQ-021 SHALL classify the word as clean when s=0 and ov=0.
REQ-022 SHALL classify SEC when ov=1 and s is 0, a power of two, or a data position <=38; when s names a data position, that data bit SHALL be flipped.
REQ-023 SHALL classify DED when s!=0 and ov=0, or when ov=1 and s>38; out_data SHALL then be the uncorrected in_data.
REQ-024 SHALL use a two-stage pipeline: stage 1 registers data, addr, s and ov; stage 2 registers the corrected outputs.
REQ-025 SHALL assert out_valid exactly 2 cycles after acceptance while the FSM stays IDLE; output order SHALL equal input order.
REQ-026 SHALL implement an FSM with states IDLE, WR_DATA and WR_PAR.
REQ-027 SHALL move the FSM IDLE->WR_DATA in the cycle after an SEC out_valid when SCRUB_EN=1.
REQ-028 SHALL move WR_DATA->WR_PAR and WR_PAR->IDLE unconditionally.
REQ-029 SHALL drive, in WR_DATA, error_dwe=1, error_addr=SEC address and error_din=corrected word.
REQ-030 SHALL drive, in WR_PAR, error_pwe=1, the same address and error_pin = check bits recomputed from the corrected word.
REQ-031 SHALL keep error_dwe and error_pwe 0 in IDLE, and SHALL never assert both in the same cycle.
REQ-032 SHALL drive in_ready = (state==IDLE); outside IDLE the stage-1 contents SHALL hold and stage 2 SHALL not advance.
REQ-033 SHALL never start a write-back on DED or clean words.
REQ-034 SHALL increment sec_count/ded_count by 1 per SEC/DED out_valid, saturating at all-ones.
REQ-035 SHALL give clear_counts priority over a simultaneous increment (result 0).

Reset
REQ-036 SHALL, on rst, set the FSM to IDLE, invalidate both pipeline stages, zero the counters and zero every output except in_ready, which SHALL read 1 in the first cycle after reset.
REQ-037 SHALL, on rst during WR_DATA or WR_PAR, abort the write-back, with error_dwe/error_pwe 0 from the next cycle.

Structure
REQ-038 SHALL place the FSM state encodings, the code width constants (32, 7, 38) and the position table in a shared edc_pkg.
REQ-039 SHALL have one combinational sub-module, edc_encode (32-bit data to 7 check bits), instantiated for syndrome generation and for error_pin.

Verification
REQ-040 SHALL cover a clean word: 0xDEADBEEF with correct parity at addr 0x05 -> out_valid at +2, out_data 0xDEADBEEF, sec/ded 0, no strobes.
REQ-041 SHALL cover single-bit correction: 0xDEADBEEF with d5 flipped at addr 0x1A0 -> out_data 0xDEADBEEF, out_sec 1, then error_dwe (0x1A0, 0xDEADBEEF), then error_pwe with correct bits, sec_count 1.
REQ-042 SHALL cover a double error: d0 and d31 flipped -> out_ded 1, out_data unchanged, no strobes, ded_count 1.
REQ-043 SHALL cover back-to-back words A, B(SEC), C -> in_ready low exactly 2 cycles, outputs in order A, B, C.
REQ-044 SHALL cover counter saturation: with COUNT_W=2, five SEC words -> sec_count 3; clear_counts concurrent with a sixth SEC -> 0.
REQ-045 SHALL cover reset mid-write-back: rst asserted in WR_PAR -> error_pwe 0 the next cycle, in_ready 1, counters 0.
